// File: rtl/div_feeder.sv
// div_feeder: queues operand pairs and runs them one at a time through the sequential divider,
// returning each result (or a watchdog timeout) on a registered valid/ready port.
module div_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_num,
    input  logic [3:0] in_denom,
    output logic       div_start,
    output logic [7:0] div_num,
    output logic [3:0] div_denom,
    input  logic       div_rdy,
    input  logic [3:0] div_quotient,
    input  logic [3:0] div_remainder,
    input  logic       div_overflow,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_num,
    output logic [3:0] out_denom,
    output logic [3:0] out_quotient,
    output logic [3:0] out_remainder,
    output logic       out_overflow,
    output logic       out_timeout,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] WMAX = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, SETTLE, WAIT} state_t;
    state_t state, state_n;
    logic [11:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [CW-1:0] wdog;
    logic push, pop, cap, tmo;
    assign in_ready  = count != FULL;
    assign push      = in_valid && in_ready;
    assign pop       = state == LAUNCH;
    assign div_start = pop;
    assign busy      = state != IDLE || count != '0;
    always_comb begin
        state_n = state;
        cap = 1'b0;
        tmo = 1'b0;
        case (state)
            IDLE:    state_n = (count != '0 && !out_valid) ? LAUNCH : IDLE;
            LAUNCH:  state_n = SETTLE;
            SETTLE:  state_n = WAIT;
            WAIT: begin
                cap = div_rdy;
                tmo = !div_rdy && wdog == WMAX;
                state_n = (cap || tmo) ? IDLE : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (push) mem[wptr] <= {in_num, in_denom};
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wdog          <= '0;
            div_num       <= '0;
            div_denom     <= '0;
            out_valid     <= 1'b0;
            out_num       <= '0;
            out_denom     <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_overflow  <= 1'b0;
            out_timeout   <= 1'b0;
        end else begin
            state <= state_n;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == IDLE && state_n == LAUNCH) {div_num, div_denom} <= mem[rptr];
            // SETTLE (and every non-WAIT state) leaves the watchdog at zero for the next WAIT
            wdog <= (state == WAIT) ? wdog + 1'b1 : '0;
            if (cap || tmo) begin
                out_valid     <= 1'b1;
                out_num       <= div_num;
                out_denom     <= div_denom;
                out_quotient  <= cap ? div_quotient : 4'h0;
                out_remainder <= cap ? div_remainder : 4'h0;
                out_overflow  <= cap ? div_overflow : 1'b1;
                out_timeout   <= tmo;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_feeder.sv
// tb_div_feeder: directed and randomized checks of div_feeder against a request-order scoreboard
// and a behavioural divider responder with programmable rdy latency.
module tb_div_feeder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, div_start, out_valid, out_ready, out_overflow, out_timeout, busy;
    logic [7:0] in_num, div_num, out_num;
    logic [3:0] in_denom, div_denom, out_denom, out_quotient, out_remainder;
    logic       div_rdy = 1'b0;
    logic       div_overflow = 1'b0;
    logic [3:0] div_quotient = 4'h0;
    logic [3:0] div_remainder = 4'h0;
    typedef struct packed {logic [7:0] n; logic [3:0] d;} req_t;
    req_t sb[$];
    int passed = 0, fails = 0, total = 0;
    int cycle = 0, starts = 0, dbl = 0, results = 0, last_start = 0;
    int lat = 3;
    bit stale = 1'b0, exp_to = 1'b0, active = 1'b0;
    int k = 0;
    logic prev_start = 1'b0;

    div_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
        .in_denom(in_denom), .div_start(div_start), .div_num(div_num), .div_denom(div_denom),
        .div_rdy(div_rdy), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_overflow(div_overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_num(out_num), .out_denom(out_denom), .out_quotient(out_quotient),
        .out_remainder(out_remainder), .out_overflow(out_overflow), .out_timeout(out_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Returns {overflow, quotient, remainder} of an 8/4 division.
    function automatic logic [8:0] ref_div(input logic [7:0] n, input logic [3:0] d);
        int q;
        if (d == 4'h0) return 9'h100;
        q = int'(n) / int'(d);
        return {q > 15, 4'(q), 4'(int'(n) % int'(d))};
    endfunction

    // Divider responder: rdy rises lat cycles after start (never if lat<0) and holds until the
    // next start; in stale mode it is also high during the launch and settle cycles.
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
            div_rdy = 1'b0;
        end else begin
            if (div_start) begin
                {div_overflow, div_quotient, div_remainder} = ref_div(div_num, div_denom);
                k = 0;
                active = 1'b1;
            end else if (active) begin
                k++;
            end
            if (active) div_rdy = (lat >= 0 && k >= lat) || (stale && k < 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_result();
        req_t e;
        logic [8:0] rr;
        logic [25:0] expv;
        if (sb.size() == 0) begin
            chk("unexpected result", 32'(out_valid), 32'(0));
            return;
        end
        e = sb.pop_front();
        rr = ref_div(e.n, e.d);
        expv = exp_to ? {e.n, e.d, 8'h00, 2'b11} : {e.n, e.d, rr[7:0], rr[8], 1'b0};
        chk("result", 32'({out_num, out_denom, out_quotient, out_remainder, out_overflow, out_timeout}),
            32'(expv));
        results++;
    endtask

    // Account for what the coming edge will transfer, then advance one cycle.
    task automatic cyc();
        if (rst) sb.delete();
        else begin
            if (in_valid && in_ready) sb.push_back('{n: in_num, d: in_denom});
            if (out_valid && out_ready) check_result();
            if (div_start) begin
                starts++;
                last_start = cycle;
                if (prev_start) dbl++;
            end
        end
        prev_start = div_start;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic send(input logic [7:0] n, input logic [3:0] d);
        in_valid = 1'b1;
        in_num = n;
        in_denom = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || out_valid || busy) && n < budget) begin
            cyc();
            n++;
        end
        chk({"drain ", tag}, 32'(n < budget), 32'(1));
    endtask

    task automatic wait_out(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            cyc();
            n++;
        end
        chk({"out_valid timeout ", tag}, 32'(out_valid), 32'(1));
    endtask

    initial begin
        int s0, r0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_num = '0; in_denom = '0;
        @(posedge clk);
        #1;
        cyc();
        chk("rst in_ready", 32'(in_ready), 32'(1));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst div", 32'({div_start, div_num, div_denom}), 32'(0));
        chk("rst out", 32'({out_valid, out_num, out_denom, out_quotient, out_remainder,
                            out_overflow, out_timeout}), 32'(0));
        rst = 1'b0;
        cyc();

        // single request, latency profile
        out_ready = 1'b1; lat = 4;
        send(8'h64, 4'h7);
        chk("c0 start", 32'(div_start), 32'(0));
        cyc();
        chk("c1 start", 32'(div_start), 32'(1));
        chk("c1 operands", 32'({div_num, div_denom}), 32'(12'h647));
        cyc();
        chk("c2 settle", 32'(div_start), 32'(0));
        repeat (3) cyc();
        chk("c5 out_valid", 32'(out_valid), 32'(0));
        cyc();
        chk("c6 out_valid", 32'(out_valid), 32'(1));
        chk("single fields", 32'({out_quotient, out_remainder, out_overflow, out_timeout}),
            32'({4'hE, 4'h2, 2'b00}));
        cyc();
        chk("c7 cleared", 32'(out_valid), 32'(0));
        wait_drain("single", 50);

        // overflow pair back-to-back
        r0 = results;
        lat = 3;
        in_valid = 1'b1; in_num = 8'hFF; in_denom = 4'h1;
        cyc();
        in_num = 8'h10; in_denom = 4'h0;
        cyc();
        in_valid = 1'b0;
        wait_drain("overflow", 100);
        chk("overflow count", results - r0, 2);

        // back-pressure fills the FIFO behind one held result
        out_ready = 1'b0;
        lat = $urandom_range(2, 6);
        s0 = starts;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_num = 8'($urandom);
            in_denom = 4'($urandom_range(1, 15));
            cyc();
        end
        in_valid = 1'b0;
        chk("bp accepted", sb.size(), DEPTH + 1);
        chk("bp in_ready", 32'(in_ready), 32'(0));
        chk("bp one start", starts - s0, 1);
        out_ready = 1'b1;
        wait_drain("bp", 300);
        chk("bp all starts", starts - s0, DEPTH + 1);

        // watchdog
        lat = -1; exp_to = 1'b1;
        send(8'h37, 4'h3);
        wait_out("watchdog", 100);
        chk("watchdog delay", cycle - last_start, TIMEOUT + 2);
        cyc();
        exp_to = 1'b0;
        chk("watchdog idle", 32'({busy, out_valid}), 32'(0));
        lat = 3;
        send(8'h9A, 4'hB);
        wait_drain("after watchdog", 50);

        // stale rdy held through launch and settle
        lat = 12; stale = 1'b1;
        send(8'h7B, 4'h9);
        wait_out("stale", 100);
        chk("stale delay", cycle - last_start, 13);
        wait_drain("stale", 50);
        stale = 1'b0;

        // randomized traffic
        lat = $urandom_range(2, 8);
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_num = 8'($urandom);
            in_denom = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain("random", 400);

        // reset mid-WAIT with requests queued
        lat = -1; out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_num = 8'(i + 1);
            in_denom = 4'h3;
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("queued before rst", sb.size(), 4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("post-rst out_valid", 32'(out_valid), 32'(0));
        chk("post-rst in_ready", 32'(in_ready), 32'(1));
        chk("post-rst busy", 32'(busy), 32'(0));
        s0 = starts;
        repeat (5) cyc();
        chk("post-rst no start", starts - s0, 0);
        lat = 3; out_ready = 1'b1;
        r0 = results;
        send(8'h2A, 4'h5);
        wait_drain("post-rst", 50);
        chk("post-rst result", results - r0, 1);

        chk("no back-to-back start", dbl, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
